multi_ctrl_seq: RTL
===================

Name: multi_ctrl_seq

Overview:
Control sequencer for the multicycle MIPS CPU, directly upstream of Multi_MainDec.
- Owns the 3-bit step counter (`state`) and the instruction register, and presents `Op` to the decoder.
- Consumes the decoder's `next_ins`, `IRWrite`, `PCWrite`, `Branch` and `IorD`, plus ALU `zero` and a memory ready handshake.
- Produces the stall-gated PC enable, a retired-instruction count and error flags (illegal opcode, step overrun).

Parameters:
- MAX_STATE, 4, last legal step; reaching it without `next_ins` forces a wrap to 0 and sets `overrun`.
- CNT_W, 16, width of the retired-instruction counter.
- INSTR_RST, 32'h0000_0000, reset value of the instruction register.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  run enable; 0 freezes all state.
- mem_ready  in  1  memory handshake; 1 = current access completes this cycle.
- instr_in  in  32  memory read data (instruction word).
- next_ins  in  1  from decoder: current step is the instruction's last.
- IRWrite  in  1  from decoder: latch `instr_in` into the IR.
- PCWrite  in  1  from decoder: unconditional PC update.
- Branch  in  1  from decoder: conditional PC update.
- IorD  in  1  from decoder: current step accesses data memory.
- zero  in  1  ALU zero flag.
- state  out  3  step number to decoder (0 fetch, 1 decode, 2..MAX_STATE execute/mem/writeback).
- Op  out  6  `instr[31:26]`, to decoder.
- Funct  out  6  `instr[5:0]`, to ALU decoder.
- instr  out  32  instruction register contents.
- pc_en  out  1  PC register enable.
- instr_count  out  CNT_W  instructions retired.
- illegal  out  1  sticky: unsupported opcode decoded.
- overrun  out  1  sticky: forced wrap at MAX_STATE.
- halted  out  1  core halted after an illegal opcode.

Behaviour:
- Async reset (`rst_n` = 0) takes effect immediately, mid-instruction included. Reset values:
  - `state` = 0, `instr` = INSTR_RST, `instr_count` = 0.
  - `illegal` = `overrun` = `halted` = 0.
  - The first rising edge after `rst_n` rises is normal operation.
- `mem_access` = (`state` == 0) | `IorD`.
- `stall` = `mem_access` & ~`mem_ready`.
- `advance` = `en` & ~`stall` & ~`halted`.
- Per-clock priority, highest first:
  1. `halted`: hold everything; `state` = 0.
  2. ~`en`: hold.
  3. `stall`: hold `state` and IR (wait states unbounded).
  4. `next_ins`: `state` <= 0; `instr_count` += 1, wrapping at 2^CNT_W.
  5. `state` == MAX_STATE: `state` <= 0; `overrun` <= 1; count not incremented.
  6. Otherwise `state` <= `state` + 1.
- IR: `instr` <= `instr_in` when `advance` & `IRWrite` & (`state` == 0). Otherwise it holds.
- `Op` and `Funct` are combinational from `instr`. In state 0 they show the previous instruction; decoder outputs in state 0 must not depend on `Op`.
- Illegal check in state 1 when `advance`:
  - Supported opcodes: 000000, 001000, 100011, 101011, 000100, 000010.
  - On any other opcode: `illegal` <= 1, `halted` <= 1, `state` <= 0. This overrides `next_ins`.
  - The instruction is not counted.
- `pc_en` = `advance` & (`PCWrite` | (`Branch` & `zero`)). Combinational, 0 while stalled, disabled or halted.
- `next_ins` asserted together with `stall`: the stall wins, and retirement happens on the cycle `mem_ready` arrives.
- Sticky flags clear only on reset.
- Latency: a full instruction takes (last step + 1) cycles plus the number of wait cycles.

Decomposition:
- Shared package `mips_ctrl_pkg`:
  - Step constants S_FETCH=0, S_DECODE=1, S_MAX=4.
  - Opcode constants OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J.
- Sub-module `op_legal_chk`: a combinational opcode-membership check. Keeping it separate lets it be reused by the decoder bench.

Test Plan:
- Reset, then `en`=1, `mem_ready`=1, `instr_in`=32'h0000_0020 (R-type), decoder `next_ins` at step 3 -> `state` runs 0,1,2,3,0; `Op`=000000, `Funct`=100000; `instr_count`=1.
- lw (`instr_in`=32'h8C01_0004), `IorD`=1 at step 3, `mem_ready`=0 for 3 cycles -> `state` holds at 3 for 3 cycles; `pc_en`=0 throughout; retires after step 4; `instr_count` +1.
- beq: `Branch`=1 at step 2 with `zero`=1 -> `pc_en`=1 for exactly one cycle. Repeat with `zero`=0 -> `pc_en` stays 0.
- Opcode 6'b111111 loaded -> at step 1 `illegal`=1, `halted`=1, `state`=0 and frozen; later `next_ins`/`PCWrite` pulses give `pc_en`=0 and the count is unchanged.
- `next_ins` held 0 -> after step 4, `state`=0, `overrun`=1, count unchanged.
- Assert `rst_n`=0 asynchronously mid-step 2 with `instr_count`=5 -> outputs clear before the next edge: `state`=0, `instr`=0, count=0, flags=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - step numbers and supported opcodes of the multicycle MIPS control path
// Contents: S_FETCH/S_DECODE/S_MAX step constants, OP_* opcode constants.
package mips_ctrl_pkg;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_MAX    = 3'd4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

endpackage

// File: rtl/op_legal_chk.sv
// rtl/op_legal_chk.sv - combinational check that an opcode is one the core implements
// Ports: op (6-bit opcode in), legal (1 when op is a supported opcode).
module op_legal_chk
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] op,
    output logic       legal
);

    always_comb begin
        legal = 1'b0;
        case (op)
            OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
            default:                                       legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multi_ctrl_seq.sv
// rtl/multi_ctrl_seq.sv - step counter, instruction register and PC-enable sequencer ahead of the main decoder
// Ports: clk, rst_n (async, active-low), en, mem_ready, instr_in;
//        decoder feedback next_ins, IRWrite, PCWrite, Branch, IorD; ALU zero;
//        outputs state, Op, Funct, instr, pc_en, instr_count, illegal, overrun, halted.
module multi_ctrl_seq
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned   MAX_STATE = 4,
    parameter int unsigned   CNT_W     = 16,
    parameter logic [31:0]   INSTR_RST = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mem_ready,
    input  logic [31:0]      instr_in,
    input  logic             next_ins,
    input  logic             IRWrite,
    input  logic             PCWrite,
    input  logic             Branch,
    input  logic             IorD,
    input  logic             zero,
    output logic [2:0]       state,
    output logic [5:0]       Op,
    output logic [5:0]       Funct,
    output logic [31:0]      instr,
    output logic             pc_en,
    output logic [CNT_W-1:0] instr_count,
    output logic             illegal,
    output logic             overrun,
    output logic             halted
);

    localparam logic [2:0]       MAX_STEP = MAX_STATE[2:0];
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             mem_access;
    logic             stall;
    logic             advance;
    logic             op_ok;

    logic [2:0]       state_nxt;
    logic [31:0]      instr_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             illegal_nxt;
    logic             overrun_nxt;
    logic             halted_nxt;

    // Fetch always touches memory; later steps only when the decoder selects data memory.
    assign mem_access = (state == S_FETCH) | IorD;
    assign stall      = mem_access & ~mem_ready;
    assign advance    = en & ~stall & ~halted;

    assign pc_en = advance & (PCWrite | (Branch & zero));
    assign Op    = instr[31:26];
    assign Funct = instr[5:0];

    op_legal_chk u_op_legal_chk (
        .op    (instr[31:26]),
        .legal (op_ok)
    );

    always_comb begin
        state_nxt   = state;
        instr_nxt   = instr;
        count_nxt   = instr_count;
        illegal_nxt = illegal;
        overrun_nxt = overrun;
        halted_nxt  = halted;

        if (halted) begin
            state_nxt = S_FETCH;
        end else if (advance) begin
            if (IRWrite && (state == S_FETCH)) begin
                instr_nxt = instr_in;
            end
            // An unsupported opcode halts the core even if the decoder claims the
            // instruction is finished; such an instruction is never counted.
            if ((state == S_DECODE) && !op_ok) begin
                illegal_nxt = 1'b1;
                halted_nxt  = 1'b1;
                state_nxt   = S_FETCH;
            end else if (next_ins) begin
                state_nxt = S_FETCH;
                count_nxt = instr_count + CNT_ONE;
            end else if (state == MAX_STEP) begin
                state_nxt   = S_FETCH;
                overrun_nxt = 1'b1;
            end else begin
                state_nxt = state + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            instr       <= INSTR_RST;
            instr_count <= '0;
            illegal     <= 1'b0;
            overrun     <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= state_nxt;
            instr       <= instr_nxt;
            instr_count <= count_nxt;
            illegal     <= illegal_nxt;
            overrun     <= overrun_nxt;
            halted      <= halted_nxt;
        end
    end

endmodule
